fp_series_accumulator: RTL
==========================

Name: fp_series_accumulator

Overview:
Sequential IEEE-754-style floating-point series summer. It accepts NUM_TERMS precomputed Taylor terms one at a time over a valid/ready handshake and accumulates them through one internal multi-cycle FP adder. It emits the final sum with a one-cycle valid pulse. It replaces fixed adder trees for exp/sin/cos evaluation: the term count and float format are parametrised, and an alternating-sign mode supports exp(-x)-type series.

Parameters:
NUM_TERMS, 6, number of terms summed per series (2..15)
EXP_W, 8, exponent field width
MAN_W, 23, mantissa field width (word width W = 1+EXP_W+MAN_W)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  begin a new series; clears accumulator and term count
alt_sign  in  1  sampled on start; 1 = negate odd-indexed terms (index 1, 3, 5, ...)
term_valid  in  1  term_data valid
term_ready  out  1  block can accept a term this cycle
term_data  in  W  term in {sign, exponent, mantissa} format
sum_valid  out  1  one-cycle pulse, sum_data final
sum_data  out  W  accumulated result, held until next start
term_idx  out  4  number of terms accepted in current series
overflow  out  1  sticky; set when any add produces exponent all-ones

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: FSM=IDLE, term_ready=0, sum_valid=0, sum_data=0, term_idx=0, overflow=0, accumulator=+0. Reset mid-series abandons all work with no output.
- FSM states and transitions:
  - IDLE: go to WAIT on start.
  - WAIT: term_ready=1; go to ALIGN on term_valid.
  - ALIGN, ADD, NORM: one cycle each.
  - After NORM: back to WAIT if term_idx<NUM_TERMS, else DONE.
  - DONE: sum_valid=1 for one cycle, then IDLE.
- Handshake: a term is accepted when term_valid&&term_ready. term_ready=1 only in WAIT. On acceptance, term_idx increments and the term is latched. If alt_sign is latched and the term index (0-based) is odd, the sign bit is inverted.
- Latency: 3 cycles per term. For back-to-back terms, the final sum_valid occurs 4*NUM_TERMS+1 cycles after the first acceptance.
- start priority: start in any state (including mid-add) clears the accumulator, term_idx and overflow, relatches alt_sign and enters WAIT. A term presented in the same cycle as start is NOT accepted. sum_data is not cleared by start.
- Adder rules:
  - ALIGN swaps operands so |A|>=|B|, then shifts B right by the exponent difference. The shift saturates at MAN_W+3; the 3 guard bits are discarded (round toward zero).
  - ADD performs a mantissa add or subtract by sign.
  - NORM handles carry-out with a right shift by 1 and exponent+1. Otherwise it does a leading-zero count and left shift, with exponent reduced accordingly.
- Special cases:
  - Exact cancellation gives +0.
  - A result exponent <=0 flushes to +0.
  - Denormal inputs (exponent 0) are treated as zero.
  - A result exponent >= all-ones gives signed infinity (mantissa 0) and sets overflow. Infinity input also gives infinity and sets overflow.
  - NaN is not supported.
- First add is +0 + term0, which yields term0 exactly.
- sum_data is updated only in DONE. The internal accumulator is not visible.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE, WAIT, ALIGN, ADD, NORM, DONE)
  - the fp field-extraction constants derived from EXP_W/MAN_W
  - the EXP_ALL_ONES constant
- One sub-module, fp_add_datapath, holds the align/add/normalise registers and the leading-zero count. It is controlled by stage enables from the FSM and is reusable by later series blocks.

Test Plan:
- Default params, alt_sign=0: terms 1.0, 2.0, 3.0, 4.0, 5.0, 6.0 presented back-to-back -> one sum_valid pulse, 25 cycles after first acceptance, sum_data=0x41A80000 (21.0), overflow=0, term_idx=6.
- alt_sign=1, same terms -> sum_data=0xC0400000 (-3.0).
- Terms 1.5, -1.5, 0, 0, 0, 0 -> sum_data=0x00000000 (+0, not -0).
- Terms 0x7F7FFFFF, 0x7F7FFFFF, 0, 0, 0, 0 -> sum_data=0x7F800000, overflow=1 held until next start.
- Assert start after 3 terms (mid-ALIGN), then present 1.0 x6 -> no sum_valid from the aborted series; sum_data=0x40C00000 (6.0). A term with valid in the start cycle is ignored.
- Pause term_valid for 5 cycles between terms; assert reset during NORM of term 4 -> all outputs return to 0 the next cycle and term_ready=0 until start.

Source files
------------

// File: rtl/fp_series_accumulator_pkg.sv
// Shared FSM state encoding and default float-format constants for the series accumulator.
// Latency: none (declarations only); backpressure: not applicable.
package fp_series_accumulator_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ALIGN,
        ADD,
        NORM,
        DONE
    } state_e;

    localparam int FP_EXP_W   = 8;
    localparam int FP_MAN_W   = 23;
    localparam int FP_W       = 1 + FP_EXP_W + FP_MAN_W;
    localparam int FP_SIGN_BIT = FP_W - 1;
    localparam int FP_EXP_MSB = FP_W - 2;
    localparam int FP_EXP_LSB = FP_MAN_W;
    localparam logic [FP_EXP_W-1:0] FP_EXP_ALL_ONES = '1;

endpackage

// File: rtl/fp_add_datapath.sv
// Three-stage FP adder (align/add/normalise) owning the running accumulator.
// Latency: one stage per enable pulse; backpressure: none, stages advance only when enabled.
module fp_add_datapath
    import fp_series_accumulator_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear_i,
    input  logic                 align_en_i,
    input  logic                 add_en_i,
    input  logic                 norm_en_i,
    input  logic [EXP_W+MAN_W:0] term_i,
    output logic [EXP_W+MAN_W:0] acc_o,
    output logic                 ovf_o
);
    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int MW     = MAN_W + 1;
    localparam int SH_MAX = MAN_W + 3;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    typedef logic signed [EXP_W+1:0] exp_s_t;

    logic [W-1:0]     acc_q;
    logic             al_sign_q, al_sub_q, al_inf_q, al_inf_sign_q;
    logic [EXP_W-1:0] al_exp_q;
    logic [MW-1:0]    al_ma_q, al_mb_q;
    logic             ad_sign_q, ad_inf_q, ad_inf_sign_q;
    logic [EXP_W-1:0] ad_exp_q;
    logic [MW:0]      ad_sum_q;

    logic             a_sign, b_sign, swap;
    logic [EXP_W-1:0] a_exp, b_exp, big_exp, small_exp;
    logic [W-2:0]     a_mag, b_mag, big_mag, small_mag;
    logic [MW-1:0]    big_m, small_m;
    logic [31:0]      diff, shamt;
    logic             al_sign_d, al_sub_d, al_inf_d, al_inf_sign_d;
    logic [MW-1:0]    al_mb_d;
    logic [MW:0]      ad_sum_d;
    logic [W-1:0]     acc_d;
    logic             norm_ovf;
    exp_s_t           e_s;
    int               lz;

    always_comb begin
        a_sign = acc_q[W-1];
        b_sign = term_i[W-1];
        a_exp  = acc_q[W-2:MAN_W];
        b_exp  = term_i[W-2:MAN_W];
        // Exponent 0 (zero or denormal) is treated as an exact zero.
        a_mag  = (a_exp == '0) ? '0 : acc_q[W-2:0];
        b_mag  = (b_exp == '0) ? '0 : term_i[W-2:0];
        swap      = b_mag > a_mag;
        big_mag   = swap ? b_mag : a_mag;
        small_mag = swap ? a_mag : b_mag;
        al_sign_d = swap ? b_sign : a_sign;
        al_sub_d  = a_sign != b_sign;
        big_exp   = big_mag[W-2:MAN_W];
        small_exp = small_mag[W-2:MAN_W];
        big_m     = (big_exp == '0) ? '0 : {1'b1, big_mag[MAN_W-1:0]};
        small_m   = (small_exp == '0) ? '0 : {1'b1, small_mag[MAN_W-1:0]};
        diff      = 32'(big_exp) - 32'(small_exp);
        shamt     = (diff > 32'(SH_MAX)) ? 32'(SH_MAX) : diff;
        // Guard bits are dropped after the shift, so shifting the bare mantissa is equivalent.
        al_mb_d   = small_m >> shamt;
        al_inf_d      = (a_exp == EXP_ONES) || (b_exp == EXP_ONES);
        al_inf_sign_d = (a_exp == EXP_ONES) ? a_sign : b_sign;

        ad_sum_d = al_sub_q ? ({1'b0, al_ma_q} - {1'b0, al_mb_q})
                            : ({1'b0, al_ma_q} + {1'b0, al_mb_q});
    end

    always_comb begin
        lz = MW;
        for (int i = 0; i < MW; i++) begin
            if (ad_sum_q[i]) lz = MW - 1 - i;
        end
        e_s      = '0;
        acc_d    = '0;
        norm_ovf = 1'b0;
        if (ad_inf_q) begin
            acc_d    = {ad_inf_sign_q, EXP_ONES, {MAN_W{1'b0}}};
            norm_ovf = 1'b1;
        end else if (ad_sum_q == '0) begin
            acc_d = '0;
        end else if (ad_sum_q[MW]) begin
            e_s = exp_s_t'({2'b00, ad_exp_q}) + exp_s_t'(1);
            if (e_s >= exp_s_t'({2'b00, EXP_ONES})) begin
                acc_d    = {ad_sign_q, EXP_ONES, {MAN_W{1'b0}}};
                norm_ovf = 1'b1;
            end else begin
                acc_d = {ad_sign_q, e_s[EXP_W-1:0], ad_sum_q[MAN_W:1]};
            end
        end else begin
            e_s = exp_s_t'({2'b00, ad_exp_q}) - exp_s_t'(lz);
            if (e_s > exp_s_t'(0)) begin
                acc_d = {ad_sign_q, e_s[EXP_W-1:0], MAN_W'(ad_sum_q[MW-1:0] << lz)};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            acc_q         <= '0;
            al_sign_q     <= 1'b0;
            al_sub_q      <= 1'b0;
            al_inf_q      <= 1'b0;
            al_inf_sign_q <= 1'b0;
            al_exp_q      <= '0;
            al_ma_q       <= '0;
            al_mb_q       <= '0;
            ad_sign_q     <= 1'b0;
            ad_inf_q      <= 1'b0;
            ad_inf_sign_q <= 1'b0;
            ad_exp_q      <= '0;
            ad_sum_q      <= '0;
        end else begin
            if (align_en_i) begin
                al_sign_q     <= al_sign_d;
                al_sub_q      <= al_sub_d;
                al_inf_q      <= al_inf_d;
                al_inf_sign_q <= al_inf_sign_d;
                al_exp_q      <= big_exp;
                al_ma_q       <= big_m;
                al_mb_q       <= al_mb_d;
            end
            if (add_en_i) begin
                ad_sign_q     <= al_sign_q;
                ad_inf_q      <= al_inf_q;
                ad_inf_sign_q <= al_inf_sign_q;
                ad_exp_q      <= al_exp_q;
                ad_sum_q      <= ad_sum_d;
            end
            if (norm_en_i) acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;
    assign ovf_o = norm_en_i & norm_ovf;

endmodule

// File: rtl/fp_series_accumulator.sv
// Sums NUM_TERMS floating-point terms through one shared adder, optional alternating signs.
// Latency: 4 cycles per back-to-back term plus 1; backpressure: term_ready only while waiting for a term.
module fp_series_accumulator
    import fp_series_accumulator_pkg::*;
#(
    parameter int NUM_TERMS = 6,
    parameter int EXP_W     = FP_EXP_W,
    parameter int MAN_W     = FP_MAN_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 alt_sign,
    input  logic                 term_valid,
    output logic                 term_ready,
    input  logic [EXP_W+MAN_W:0] term_data,
    output logic                 sum_valid,
    output logic [EXP_W+MAN_W:0] sum_data,
    output logic [3:0]           term_idx,
    output logic                 overflow
);
    localparam int W = 1 + EXP_W + MAN_W;

    state_e       state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic [W-1:0] term_q, term_d;
    logic [W-1:0] sum_q, sum_d;
    logic         alt_q, alt_d;
    logic         ovf_q, ovf_d;
    logic         sv_q, sv_d;
    logic         accept;
    logic [W-1:0] acc;
    logic         add_ovf;

    always_comb begin
        state_d    = state_q;
        term_ready = 1'b0;
        case (state_q)
            IDLE:    state_d = IDLE;
            WAIT: begin
                term_ready = 1'b1;
                if (term_valid) state_d = ALIGN;
            end
            ALIGN:   state_d = ADD;
            ADD:     state_d = NORM;
            NORM:    state_d = (idx_q < 4'(NUM_TERMS)) ? WAIT : DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // start overrides everything, even an add in flight.
        if (start) state_d = WAIT;

        accept = term_valid && term_ready && !start;
        idx_d  = start ? 4'd0 : (accept ? idx_q + 4'd1 : idx_q);
        term_d = accept ? (term_data ^ {alt_q & idx_q[0], {(W-1){1'b0}}}) : term_q;
        alt_d  = start ? alt_sign : alt_q;
        ovf_d  = start ? 1'b0 : (ovf_q | add_ovf);
        sv_d   = (state_q == DONE) && !start;
        sum_d  = sv_d ? acc : sum_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            term_q  <= '0;
            sum_q   <= '0;
            alt_q   <= 1'b0;
            ovf_q   <= 1'b0;
            sv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            term_q  <= term_d;
            sum_q   <= sum_d;
            alt_q   <= alt_d;
            ovf_q   <= ovf_d;
            sv_q    <= sv_d;
        end
    end

    fp_add_datapath #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_dp (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (start),
        .align_en_i (state_q == ALIGN),
        .add_en_i   (state_q == ADD),
        .norm_en_i  (state_q == NORM),
        .term_i     (term_q),
        .acc_o      (acc),
        .ovf_o      (add_ovf)
    );

    assign sum_valid = sv_q;
    assign sum_data  = sum_q;
    assign term_idx  = idx_q;
    assign overflow  = ovf_q;

endmodule
